// File: rtl/elc3_pkg.sv
// eLC-3 memory/I-O shared definitions.
// Memory-mapped I/O register addresses and access FSM states.
package elc3_pkg;

  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;
  localparam logic [6:0]  IO_PAGE_PREFIX = 7'h7F;

  typedef enum logic [2:0] {
    IDLE,
    SRAM_ACC,
    IO_ACC,
    DDR_STALL,
    DONE,
    RELEASE
  } mio_state_t;

  function automatic logic is_io(input logic [15:0] a);
    return a[15:9] == IO_PAGE_PREFIX;
  endfunction

endpackage

// File: rtl/mem_io_regs.sv
// Keyboard and display registers of the eLC-3 I/O page.
// Captures keyboard strobes and runs the display valid/ready handshake.
module mem_io_regs
  import elc3_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  input  logic        rd_kbdr,
  input  logic        ddr_wr,
  input  logic [7:0]  ddr_wdata,
  input  logic        ddr_ready,
  output logic [15:0] kbsr,
  output logic [15:0] kbdr,
  output logic        ddr_valid,
  output logic [7:0]  ddr_data
);

  logic       kb_rdy_q, kb_rdy_d;
  logic       kb_ovr_q, kb_ovr_d;
  logic [7:0] kb_chr_q, kb_chr_d;
  logic       ddr_vld_q, ddr_vld_d;
  logic [7:0] ddr_chr_q, ddr_chr_d;

  always_comb begin
    kb_rdy_d  = kb_rdy_q;
    kb_ovr_d  = kb_ovr_q;
    kb_chr_d  = kb_chr_q;
    ddr_vld_d = ddr_vld_q;
    ddr_chr_d = ddr_chr_q;
    // a char arriving with the KBDR read beats the clear
    if (kb_valid) begin
      kb_chr_d = kb_data;
      kb_rdy_d = 1'b1;
      kb_ovr_d = rd_kbdr ? 1'b0 : (kb_ovr_q | kb_rdy_q);
    end else if (rd_kbdr) begin
      kb_rdy_d = 1'b0;
      kb_ovr_d = 1'b0;
    end
    if (ddr_wr) begin
      ddr_vld_d = 1'b1;
      ddr_chr_d = ddr_wdata;
    end else if (ddr_vld_q && ddr_ready) begin
      ddr_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kb_rdy_q  <= 1'b0;
      kb_ovr_q  <= 1'b0;
      kb_chr_q  <= 8'h00;
      ddr_vld_q <= 1'b0;
      ddr_chr_q <= 8'h00;
    end else begin
      kb_rdy_q  <= kb_rdy_d;
      kb_ovr_q  <= kb_ovr_d;
      kb_chr_q  <= kb_chr_d;
      ddr_vld_q <= ddr_vld_d;
      ddr_chr_q <= ddr_chr_d;
    end
  end

  assign kbsr      = {kb_rdy_q, kb_ovr_q, 14'b0};
  assign kbdr      = {8'h00, kb_chr_q};
  assign ddr_valid = ddr_vld_q;
  assign ddr_data  = ddr_chr_q;

endmodule

// File: rtl/memory_io_unit.sv
// eLC-3 memory/I-O access unit: SRAM sequencing with wait states
// plus the memory-mapped keyboard/display page.
module memory_io_unit
  import elc3_pkg::*;
#(
  parameter int WAIT_STATES = 2,
  parameter int DATA_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MIO_EN,
  input  logic              R_W,
  input  logic [DATA_W-1:0] MAR,
  input  logic [DATA_W-1:0] MDR,
  output logic [DATA_W-1:0] MEM_Data,
  output logic              R,
  output logic [DATA_W-1:0] SRAM_ADDR,
  output logic [DATA_W-1:0] SRAM_DQ_O,
  input  logic [DATA_W-1:0] SRAM_DQ_I,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  input  logic              KB_Valid,
  input  logic [7:0]        KB_Data,
  output logic              DDR_Valid,
  output logic [7:0]        DDR_Data,
  input  logic              DDR_Ready
);

  localparam int CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

  mio_state_t        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;
  logic              rw_q, rw_d;
  logic [DATA_W-1:0] mdat_q, mdat_d;
  logic              r_q, r_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;

  logic              rd_kbdr;
  logic              ddr_wr;
  logic [15:0]       kbsr;
  logic [15:0]       kbdr;
  logic [15:0]       io_rd;

  mem_io_regs u_regs (
    .clk       (clk),
    .rst_n     (rst_n),
    .kb_valid  (KB_Valid),
    .kb_data   (KB_Data),
    .rd_kbdr   (rd_kbdr),
    .ddr_wr    (ddr_wr),
    .ddr_wdata (wdat_q[7:0]),
    .ddr_ready (DDR_Ready),
    .kbsr      (kbsr),
    .kbdr      (kbdr),
    .ddr_valid (DDR_Valid),
    .ddr_data  (DDR_Data)
  );

  always_comb begin
    io_rd = 16'h0000;
    unique case (1'b1)
      addr_q == KBSR_ADDR: io_rd = kbsr;
      addr_q == KBDR_ADDR: io_rd = kbdr;
      addr_q == DSR_ADDR:  io_rd = {!DDR_Valid, 15'b0};
      default:             io_rd = 16'h0000;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    rw_d    = rw_q;
    mdat_d  = mdat_q;
    r_d     = 1'b0;
    ce_n_d  = ce_n_q;
    oe_n_d  = oe_n_q;
    we_n_d  = we_n_q;
    rd_kbdr = 1'b0;
    ddr_wr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (MIO_EN) begin
          addr_d = MAR;
          wdat_d = MDR;
          rw_d   = R_W;
          if (is_io(MAR)) begin
            state_d = IO_ACC;
          end else begin
            state_d = SRAM_ACC;
            cnt_d   = CW'(WAIT_STATES - 1);
            ce_n_d  = 1'b0;
            oe_n_d  = R_W;
            we_n_d  = !R_W;
          end
        end
      end
      SRAM_ACC: begin
        if (cnt_q == '0) begin
          if (!rw_q) mdat_d = SRAM_DQ_I;
          ce_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          we_n_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      IO_ACC: begin
        state_d = DONE;
        if (rw_q) begin
          if (addr_q == DDR_ADDR) begin
            if (DDR_Valid) state_d = DDR_STALL;
            else           ddr_wr  = 1'b1;
          end
        end else begin
          mdat_d  = io_rd;
          rd_kbdr = (addr_q == KBDR_ADDR);
        end
      end
      DDR_STALL: begin
        if (!DDR_Valid) begin
          ddr_wr  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        r_d     = 1'b1;
        state_d = RELEASE;
      end
      RELEASE: begin
        if (!MIO_EN) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
      rw_q    <= 1'b0;
      mdat_q  <= '0;
      r_q     <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      rw_q    <= rw_d;
      mdat_q  <= mdat_d;
      r_q     <= r_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
    end
  end

  assign MEM_Data  = mdat_q;
  assign R         = r_q;
  assign SRAM_ADDR = addr_q;
  assign SRAM_DQ_O = wdat_q;
  assign SRAM_CE_N = ce_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_WE_N = we_n_q;

endmodule
